uart_tx_sched: RTL

Round-robin scheduler and frame sequencer that shares one UART transmit path among `NUM_REQ` byte sources. It selects a requester and captures its byte. It then drives `tx_start` and `tx_done` to the baud-rate clock generator and serializes the frame on `txd`, one bit per `bps_clk` pulse. It sits between the on-chip byte producers and the UART pin, paired with `tx_clk_gen`.

---
 rtl/uart_tx_sched.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
//============================================================================
// Module      : uart_tx_sched
// Description : Round-robin scheduler and frame sequencer sharing one UART
//               transmit path among NUM_REQ byte sources. Grants one
//               requester at a time, captures its byte, pulses tx_start /
//               tx_done towards the baud generator (tx_clk_gen) and
//               serialises the frame on txd, one bit per bps_clk tick.
// Revision    : 1.0 - initial release
//----------------------------------------------------------------------------
// Parameters
//   NUM_REQ    number of requesters (2..8)
//   DATA_W     data bits per frame
// Ports
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   req_valid  per-requester byte pending (held until accepted)
//   req_data   requester i byte at [i*DATA_W +: DATA_W]
//   req_ready  one-hot accept, combinational, only while idle
//   bps_clk    one-cycle baud tick from the baud generator
//   tx_start   one-cycle pulse starting the baud generator
//   tx_done    one-cycle pulse stopping the baud generator at frame end
//   txd        serial line, idles high
//   busy       high from acceptance until tx_done
//   grant_id   index of the requester currently or last served
// Build option
//   UART_TX_PARITY_EN  when defined, an even-parity bit (XOR of the data
//                      bits) follows the last data bit.
//============================================================================
module uart_tx_sched #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic                       bps_clk,
    output logic                       tx_start,
    output logic                       tx_done,
    output logic                       txd,
    output logic                       busy,
    output logic [$clog2(NUM_REQ)-1:0] grant_id
);

    localparam int c_ID_W = $clog2(NUM_REQ);
`ifdef UART_TX_PARITY_EN
    localparam int c_PAR_BITS = 1;
`else
    localparam int c_PAR_BITS = 0;
`endif
    // start + data + [parity] + stop
    localparam int c_FRAME_BITS = DATA_W + 2 + c_PAR_BITS;
    localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_SHIFT = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [c_ID_W-1:0]       r_last_grant;
    logic [c_ID_W-1:0]       r_grant_id;
    logic [c_FRAME_BITS-1:0] r_shift;
    logic [c_CNT_W-1:0]      r_bit_cnt;
    logic                    r_txd;

    logic                    w_found;
    logic [c_ID_W-1:0]       w_win;
    logic                    w_accept;
    logic                    w_shift_tick;
    logic                    w_frame_end;
    logic [DATA_W-1:0]       w_sel_data;
    logic [c_FRAME_BITS-1:0] w_frame;

    //------------------------------------------------------------------------
    // Round-robin search: starts one past the last grant and wraps, so a
    // requester that keeps req_valid high waits behind every other pending
    // requester before it is served again.
    //------------------------------------------------------------------------
    always_comb begin : p_arb
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_win   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = (int'(r_last_grant) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_win   = c_ID_W'(idx);
            end
        end
    end

    assign w_accept   = (r_state == c_ST_IDLE) && w_found;
    assign w_sel_data = req_data[int'(w_win)*DATA_W +: DATA_W];

    // Whole frame is prepared at acceptance; bit 0 goes out first.
`ifdef UART_TX_PARITY_EN
    assign w_frame = {1'b1, ^w_sel_data, w_sel_data, 1'b0};
`else
    assign w_frame = {1'b1, w_sel_data, 1'b0};
`endif

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = w_accept && (w_win == c_ID_W'(gi));
        end
    endgenerate

    // A tick either emits the next frame bit or, once every bit has been
    // emitted, closes the stop bit's baud period and ends the frame.
    assign w_shift_tick = (r_state == c_ST_SHIFT) && bps_clk &&
                          (r_bit_cnt < c_CNT_W'(c_FRAME_BITS));
    assign w_frame_end  = (r_state == c_ST_SHIFT) && bps_clk &&
                          (r_bit_cnt == c_CNT_W'(c_FRAME_BITS));

    //------------------------------------------------------------------------
    // Frame sequencer
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        tx_start    = 1'b0;
        tx_done     = 1'b0;
        busy        = 1'b1;
        case (r_state)
            c_ST_IDLE: begin
                busy = 1'b0;
                if (w_found) begin
                    w_state_nxt = c_ST_START;
                end
            end
            c_ST_START: begin
                // bps_clk is deliberately not looked at here.
                tx_start    = 1'b1;
                w_state_nxt = c_ST_SHIFT;
            end
            c_ST_SHIFT: begin
                if (w_frame_end) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                tx_done     = 1'b1;
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                busy        = 1'b0;
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------------
    // Datapath: grant bookkeeping, shift register and line driver
    //------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= c_ID_W'(NUM_REQ - 1);
            r_grant_id   <= '0;
            r_shift      <= '1;
            r_bit_cnt    <= '0;
            r_txd        <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_win;
            r_grant_id   <= w_win;
            r_shift      <= w_frame;
            r_bit_cnt    <= '0;
            r_txd        <= 1'b1;
        end else if (w_shift_tick) begin
            r_txd     <= r_shift[0];
            // Refill with ones so the line sits at mark once drained.
            r_shift   <= {1'b1, r_shift[c_FRAME_BITS-1:1]};
            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
        end
    end

    assign txd      = r_txd;
    assign grant_id = r_grant_id;

endmodule
`default_nettype wire
